// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Word-addressed data-memory responder with a valid/ready request
//             and response handshake, programmable commit latency, and
//             alignment/range checking. Define MEM_STATS_EN to enable the
//             saturating load/store statistics counters.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic [CNTW-1:0] rd_count,
    output logic [CNTW-1:0] wr_count
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_mem [DEPTH];

    logic           w_err;
    logic           w_commit;
    logic [c_AW-1:0] w_idx;

    // Upper address bits are compared in full so that out-of-range never aliases.
    assign w_err    = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= 32'(DEPTH));
    assign w_idx    = r_addr[c_AW+1:2];
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign req_ready = reset && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= 4'(LATENCY);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= w_err;
                        resp_rdata <= (!w_err && !r_we) ? r_mem[w_idx] : 32'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state    <= S_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Storage is never cleared; an abandoned store cannot reach its commit edge.
    always_ff @(posedge clk) begin
        if (reset && w_commit && r_we && !w_err) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

`ifdef MEM_STATS_EN
    logic [CNTW-1:0] r_rd_count;
    logic [CNTW-1:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_commit && !w_err) begin
            if (r_we) begin
                if (r_wr_count != {CNTW{1'b1}}) r_wr_count <= r_wr_count + 1'b1;
            end else begin
                if (r_rd_count != {CNTW{1'b1}}) r_rd_count <= r_rd_count + 1'b1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Randomized scoreboard bench for mem_responder against an
//             array-based memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;
    localparam int CNTW    = 2;
    localparam int SAT     = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_rdata;
    logic            resp_err;
    logic [CNTW-1:0] rd_count;
    logic [CNTW-1:0] wr_count;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          rd_m = 0;
    int          wr_m = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] stat_exp(input int n);
`ifdef MEM_STATS_EN
        return 32'((n > SAT) ? SAT : n);
`else
        return 32'(n - n);
`endif
    endfunction

    // Reference behaviour: one outstanding request, so applying it at issue keeps commit order.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output exp_t e);
        logic err;
        err = ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
        e.err   = err;
        e.rdata = 32'd0;
        e.acc   = 0;
        if (!err) begin
            if (we) begin
                model_mem[addr / 4] = wdata;
                wr_m++;
            end else begin
                e.rdata = model_mem[addr / 4];
                rd_m++;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (t=%0t)", $time);
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        wait_ready();
        if (!req_ready) return;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model(we, addr, wdata, e);
        e.acc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || !req_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd_m = 0;
        wr_m = 0;
    endtask

    always begin
        @(posedge clk);
        #2;
        resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares every presented response against the head of the scoreboard.
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && resp_valid) begin
                check("busy_req_ready", 32'(req_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata=%h err=%0d expected none",
                             resp_rdata, resp_err);
                end else begin
                    e = exp_q[0];
                    if (!prev) check("latency", 32'(cyc - e.acc), 32'(LATENCY + 1));
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    if (resp_ready) void'(exp_q.pop_front());
                end
            end
            prev = reset && resp_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          sel;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("init_req_ready", 32'(req_ready), 32'd0);
        check("init_resp_valid", 32'(resp_valid), 32'd0);
        check("init_resp_rdata", resp_rdata, 32'd0);
        check("init_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(4 * i), $urandom);

        do_req(1'b1, 32'h64, 32'd7);
        do_req(1'b0, 32'h64, 32'd0);
        do_req(1'b1, 32'h66, 32'h55);
        do_req(1'b0, 32'h64, 32'd0);
        do_req(1'b0, 32'h100, 32'd0);
        do_req(1'b0, 32'hFC, 32'd0);
        drain();

        // Response held off while a stray request pulse must be ignored.
        hold = 1'b1;
        do_req(1'b0, 32'h64, 32'd0);
        begin
            int n = 0;
            while (!resp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_resp_valid", 32'(resp_valid), 32'd1);
            req_valid = (i == 2);
            req_we    = 1'b1;
            req_addr  = 32'h64;
            req_wdata = 32'hDEAD;
        end
        req_valid = 1'b0;
        hold = 1'b0;
        do_req(1'b0, 32'h64, 32'd0);
        drain();

        // Store abandoned by reset while waiting to commit.
        do_req(1'b1, 32'h60, 32'h11);
        drain();
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h60;
        req_wdata = 32'hAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd_m = 0;
        wr_m = 0;
        do_req(1'b0, 32'h60, 32'd0);
        drain();

        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (sel == 7) a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else if (sel == 8) a = 32'(4 * $urandom_range(DEPTH, DEPTH + 8));
            else               a = $urandom | 32'h8000_0000;
            do_req(1'($urandom_range(0, 1)), a, $urandom);
        end
        drain();
        check("rand_rd_count", 32'(rd_count), stat_exp(rd_m));
        check("rand_wr_count", 32'(wr_count), stat_exp(wr_m));

        do_reset();
        for (int i = 0; i < 4; i++) do_req(1'b0, 32'(4 * i), 32'd0);
        do_req(1'b1, 32'h10, 32'h1234);
        do_req(1'b1, 32'h14, 32'h5678);
        do_req(1'b1, 32'h16, 32'h9);
        drain();
        check("stat_rd_count", 32'(rd_count), stat_exp(rd_m));
        check("stat_wr_count", 32'(wr_count), stat_exp(wr_m));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
